fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request, a hold stage towards the fetch
// pipeline, and redirect handling that drains an in-flight request. Optional FETCH_MISALIGN_CHECK_EN.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic [63:0] pc,
  output logic [31:0] raw_instr,
  output logic        instr_valid,
  output logic        exc_misalign
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  state_t      state;
  logic [63:0] target;
  logic        exc_q;
  logic        misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // The request is gated by reset so it appears in the very first cycle after release.
  assign ireq_valid   = reset && (((state == FETCH) && !misalign) || (state == DRAIN));
  assign ireq_addr    = pc;
  assign instr_valid  = (state == HOLD);
  assign exc_misalign = exc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      raw_instr <= '0;
      exc_q     <= 1'b0;
      target    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (misalign) begin
            if (redirect_valid) begin
              pc <= redirect_pc;
            end else begin
              raw_instr <= NOP;
              exc_q     <= 1'b1;
              state     <= HOLD;
            end
          end else if (iresp_data_ok) begin
            if (redirect_valid) begin
              pc <= redirect_pc;
            end else begin
              raw_instr <= iresp_data;
              state     <= HOLD;
            end
          end else if (redirect_valid) begin
            // pc keeps addressing the outstanding request until its response arrives.
            target <= redirect_pc;
            state  <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            exc_q <= 1'b0;
            state <= FETCH;
          end else if (!stallF) begin
            pc    <= pc + 64'd4;
            exc_q <= 1'b0;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (iresp_data_ok) begin
            pc    <= redirect_valid ? redirect_pc : target;
            state <= FETCH;
          end else if (redirect_valid) begin
            target <= redirect_pc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
